fp_addsub: RTL

Parametrised IEEE-754 binary floating-point adder/subtractor with valid/ready handshakes on input and output. Computes `a + b`, or `a - b` when `sub` is set. Full round-to-nearest-even, subnormal inputs and outputs, and exception flags. Sits in the core datapath as the generalised successor of the fixed fp32 adder. Default parameters give binary32; `EXP_W=11, MAN_W=52` gives binary64.

---
 rtl/fp_addsub.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub.sv
// fp_addsub: parametrised IEEE-754 adder/subtractor.
// Multi-cycle FSM (UNPACK/ALIGN/ADD/NORM/ROUND/OUT) with valid/ready on both sides.
// Round-to-nearest-even, subnormals, {invalid, overflow, inexact} flags.
module fp_addsub #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   z,
   output logic [2:0]             flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int M  = MAN_W + 4;              // {hidden, fraction, G, R, S}
   localparam int LW = $clog2(MAN_W + 5);
   localparam int SW = (LW > EXP_W + 2) ? LW : EXP_W + 2;   // exponent / shift arithmetic width
   localparam logic [SW-1:0] EMAX = SW'((1 << EXP_W) - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_ALIGN  = 3'd2;
   localparam logic [2:0] S_ADD    = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_ROUND  = 3'd5;
   localparam logic [2:0] S_OUT    = 3'd6;

   logic [2:0]    r_state;
   logic [W-1:0]  r_a, r_b;
   logic          r_spec;
   logic [W-1:0]  r_spec_z;
   logic [2:0]    r_spec_f;
   logic          r_sx, r_sy;
   logic [SW-1:0] r_ex, r_ey, r_e;
   logic [M-1:0]  r_mx, r_my, r_m;
   logic [M:0]    r_sum;
   logic [W-1:0]  r_z;
   logic [2:0]    r_flags;
   logic          r_out_valid;

   // ---- unpack / special-case decode ----
   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_big;
   logic [W-1:0]     w_qnan;
   logic [SW-1:0]    w_eea, w_eeb;
   logic [M-1:0]     w_xa, w_xb;

   assign w_ea     = r_a[W-2:MAN_W];
   assign w_eb     = r_b[W-2:MAN_W];
   assign w_fa     = r_a[MAN_W-1:0];
   assign w_fb     = r_b[MAN_W-1:0];
   assign w_a_nan  = (&w_ea) & (|w_fa);
   assign w_b_nan  = (&w_eb) & (|w_fb);
   assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
   assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
   assign w_a_inf  = (&w_ea) & ~(|w_fa);
   assign w_b_inf  = (&w_eb) & ~(|w_fb);
   assign w_qnan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   // raw magnitude bits order the same way as the values they encode
   assign w_a_big  = r_a[W-2:0] >= r_b[W-2:0];
   // exponent field 0 behaves as exponent 1 with hidden bit 0
   assign w_eea    = (|w_ea) ? SW'(w_ea) : SW'(1);
   assign w_eeb    = (|w_eb) ? SW'(w_eb) : SW'(1);
   assign w_xa     = {|w_ea, w_fa, 3'b000};
   assign w_xb     = {|w_eb, w_fb, 3'b000};

   // ---- align: smaller operand right-shifted, lost bits folded into sticky ----
   logic [SW-1:0] w_diff, w_sh;
   logic [M-1:0]  w_mask, w_my_al;

   assign w_diff  = r_ex - r_ey;
   assign w_sh    = (w_diff > SW'(M)) ? SW'(M) : w_diff;
   assign w_mask  = ~({M{1'b1}} << w_sh);
   assign w_my_al = (r_my >> w_sh) | {{(M-1){1'b0}}, |(r_my & w_mask)};

   // ---- normalise: leading-zero count of the sum below the carry bit ----
   logic [SW-1:0] w_lzc, w_lim, w_nsh;

   // priority scan, the highest set bit wins
   always_comb begin
      w_lzc = SW'(M);
      for (int i = 0; i < M; i++)
         if (r_sum[i]) w_lzc = SW'(M - 1 - i);
   end

   // never shift the exponent below 1; the remainder stays subnormal
   assign w_lim = r_e - SW'(1);
   assign w_nsh = (w_lzc > w_lim) ? w_lim : w_lzc;

   // ---- round to nearest even and pack ----
   logic             w_inc, w_hid, w_ovf, w_zero, w_sign, w_inx;
   logic [MAN_W+1:0] w_sig;
   logic [SW-1:0]    w_e_rnd;
   logic [MAN_W-1:0] w_frac;
   logic [EXP_W-1:0] w_exp_f;
   logic [W-1:0]     w_res;

   assign w_inc   = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
   assign w_sig   = {1'b0, r_m[M-1:3]} + (MAN_W+2)'(w_inc);
   assign w_e_rnd = w_sig[MAN_W+1] ? r_e + SW'(1) : r_e;
   assign w_frac  = w_sig[MAN_W+1] ? w_sig[MAN_W:1] : w_sig[MAN_W-1:0];
   assign w_hid   = w_sig[MAN_W+1] | w_sig[MAN_W];
   assign w_ovf   = w_e_rnd >= EMAX;
   assign w_exp_f = w_hid ? w_e_rnd[EXP_W-1:0] : '0;
   assign w_zero  = ~(|r_m);
   // exact zero is +0 unless both operands were negative
   assign w_sign  = w_zero ? (r_sx & r_sy) : r_sx;
   assign w_inx   = (|r_m[2:0]) | w_ovf;
   assign w_res   = w_ovf ? {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {w_sign, w_exp_f, w_frac};

   // datapath registers, advanced by the state the FSM is in
   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE: if (in_valid) begin
            r_a <= a;
            r_b <= {b[W-1] ^ sub, b[W-2:0]};
         end
         S_UNPACK: begin
            r_spec   <= w_a_nan | w_b_nan | w_a_inf | w_b_inf;
            r_spec_f <= 3'b000;
            if (w_a_nan | w_b_nan) begin
               r_spec_z <= w_qnan;
               r_spec_f <= {w_a_snan | w_b_snan, 2'b00};
            end else if (w_a_inf & w_b_inf & (r_a[W-1] != r_b[W-1])) begin
               r_spec_z <= w_qnan;
               r_spec_f <= 3'b100;
            end else if (w_a_inf)
               r_spec_z <= r_a;
            else
               r_spec_z <= r_b;
            r_sx <= w_a_big ? r_a[W-1] : r_b[W-1];
            r_sy <= w_a_big ? r_b[W-1] : r_a[W-1];
            r_ex <= w_a_big ? w_eea : w_eeb;
            r_ey <= w_a_big ? w_eeb : w_eea;
            r_mx <= w_a_big ? w_xa : w_xb;
            r_my <= w_a_big ? w_xb : w_xa;
         end
         S_ALIGN: r_my <= w_my_al;
         S_ADD: begin
            r_sum <= (r_sx == r_sy) ? {1'b0, r_mx} + {1'b0, r_my}
                                    : {1'b0, r_mx} - {1'b0, r_my};
            r_e   <= r_ex;
         end
         S_NORM: begin
            if (r_sum[M]) begin
               r_m <= {r_sum[M:2], r_sum[1] | r_sum[0]};
               r_e <= r_e + SW'(1);
            end else begin
               r_m <= r_sum[M-1:0] << w_nsh;
               r_e <= r_e - w_nsh;
            end
         end
         default: ;
      endcase
   end

   // control FSM and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_z         <= '0;
         r_flags     <= '0;
      end else begin
         case (r_state)
            S_IDLE:   if (in_valid) r_state <= S_UNPACK;
            S_UNPACK: r_state <= S_ALIGN;
            S_ALIGN:  r_state <= S_ADD;
            S_ADD:    r_state <= S_NORM;
            S_NORM:   r_state <= S_ROUND;
            S_ROUND: begin
               r_z     <= r_spec ? r_spec_z : w_res;
               r_flags <= r_spec ? r_spec_f : {1'b0, w_ovf, w_inx};
               r_state <= S_OUT;
            end
            S_OUT: begin
               if (!r_out_valid)
                  r_out_valid <= 1'b1;
               else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign z         = r_z;
   assign flags     = r_flags;
endmodule
